// File: rtl/tx_dp_scrambler_if.sv
// Byte-stream bundle between the ordered-set/framing generator, the scrambler and the 8b/10b encoder.
// OutScXor exists only when TX_DP_SCXOR_OUT_EN is defined.
interface tx_dp_scrambler_if;
    logic       InValid;
    logic [7:0] InByte;
    logic       InControl;
    logic       InNoScramble;
    logic       DisableScrambling;
    logic       OutValid;
    logic [7:0] OutByte;
    logic       OutControl;
`ifdef TX_DP_SCXOR_OUT_EN
    logic [7:0] OutScXor;
`endif

    modport master (
        output InValid, InByte, InControl, InNoScramble, DisableScrambling,
`ifdef TX_DP_SCXOR_OUT_EN
        input  OutScXor,
`endif
        input  OutValid, OutByte, OutControl
    );

    modport slave (
        input  InValid, InByte, InControl, InNoScramble, DisableScrambling,
`ifdef TX_DP_SCXOR_OUT_EN
        output OutScXor,
`endif
        output OutValid, OutByte, OutControl
    );
endinterface

// File: rtl/tx_dp_scrambler.sv
// Single-lane PCIe transmit scrambler: 16-bit Galois LFSR, COM reseeds, SKP holds, one cycle latency.
// Optional TX_DP_SCXOR_OUT_EN adds OutScXor, the keystream byte applied to each output byte.
module tx_dp_scrambler #(
    parameter logic [15:0] LFSR_SEED = 16'hFFFF,
    parameter logic [7:0]  COM_BYTE  = 8'hBC,
    parameter logic [7:0]  SKP_BYTE  = 8'h1C
) (
    input logic              ClkPci,
    input logic              Reset,
    tx_dp_scrambler_if.slave bus
);
    // X^16 + X^5 + X^4 + X^3 + 1: feedback lands on bits 0, 3, 4, 5
    localparam logic [15:0] TAPS = 16'h0039;

    logic [15:0] lfsr;
    logic [15:0] lfsrAdv;
    logic [15:0] lfsrNext;
    logic [7:0]  scXor;
    logic [7:0]  byteNext;
    logic        isCom;
    logic        isSkp;
    logic        scrambleNow;
    logic        outValidQ;
    logic        outControlQ;
    logic [7:0]  outByteQ;

    // ScXor bit i is LFSR[15] ahead of shift i; bit 0 leaves the wire first
    always_comb begin
        lfsrAdv = lfsr;
        scXor   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            scXor[i] = lfsrAdv[15];
            lfsrAdv  = {lfsrAdv[14:0], 1'b0} ^ (lfsrAdv[15] ? TAPS : 16'h0000);
        end
    end

    assign isCom       = bus.InControl && (bus.InByte == COM_BYTE);
    assign isSkp       = bus.InControl && (bus.InByte == SKP_BYTE);
    assign scrambleNow = bus.InValid && !bus.InControl
                         && !bus.InNoScramble && !bus.DisableScrambling;

    always_comb begin
        lfsrNext = lfsr;
        byteNext = scrambleNow ? (bus.InByte ^ scXor) : bus.InByte;
        if (bus.InValid) begin
            if (isCom) begin
                lfsrNext = LFSR_SEED;
            end else if (!isSkp) begin
                lfsrNext = lfsrAdv;
            end
        end
    end

    always_ff @(posedge ClkPci) begin
        if (Reset) begin
            lfsr        <= LFSR_SEED;
            outValidQ   <= 1'b0;
            outByteQ    <= 8'h00;
            outControlQ <= 1'b0;
        end else begin
            lfsr      <= lfsrNext;
            outValidQ <= bus.InValid;
            if (bus.InValid) begin
                outByteQ    <= byteNext;
                outControlQ <= bus.InControl;
            end
        end
    end

    assign bus.OutValid   = outValidQ;
    assign bus.OutByte    = outByteQ;
    assign bus.OutControl = outControlQ;

`ifdef TX_DP_SCXOR_OUT_EN
    logic [7:0] scXorQ;

    always_ff @(posedge ClkPci) begin
        if (Reset) begin
            scXorQ <= 8'h00;
        end else if (bus.InValid) begin
            scXorQ <= scrambleNow ? scXor : 8'h00;
        end
    end

    assign bus.OutScXor = scXorQ;
`endif
endmodule

// File: tb/tb_tx_dp_scrambler.sv
// Self-checking bench for tx_dp_scrambler: directed cases with known PCIe keystream bytes plus randomized traffic.
// Checks OutScXor as well when built with TX_DP_SCXOR_OUT_EN.
module tb_tx_dp_scrambler;
    logic ClkPci = 1'b0;
    logic Reset  = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    logic [7:0] keyStream [0:4095];

    tx_dp_scrambler_if bus ();

    tx_dp_scrambler dut (
        .ClkPci (ClkPci),
        .Reset  (Reset),
        .bus    (bus)
    );

    always #5 ClkPci = ~ClkPci;

    // Keystream table: byte k is the scrambler byte k positions after a reseed
    task automatic build_keystream();
        logic [15:0] state;
        logic        bitOut;
        state = 16'hFFFF;
        for (int k = 0; k < 4096; k++) begin
            for (int b = 0; b < 8; b++) begin
                bitOut = state[15];
                keyStream[k][b] = bitOut;
                state = (state << 1) ^ (bitOut ? 16'h0039 : 16'h0000);
            end
        end
    endtask

    task automatic send(input logic v, input logic [7:0] b, input logic c, input logic ns);
        bus.InValid      = v;
        bus.InByte       = b;
        bus.InControl    = c;
        bus.InNoScramble = ns;
        @(posedge ClkPci);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.DisableScrambling = 1'b0;
        send(1'b1, 8'h5A, 1'b0, 1'b0);
        send(1'b1, 8'hBC, 1'b1, 1'b0);
        total++;
        if (bus.OutValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.OutValid); end
        total++;
        if (bus.OutByte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", bus.OutByte); end
        total++;
        if (bus.OutControl !== 1'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=0", bus.OutControl); end
`ifdef TX_DP_SCXOR_OUT_EN
        total++;
        if (bus.OutScXor !== 8'h00) begin bad++; $display("FAIL reset_scxor got=%h exp=00", bus.OutScXor); end
`endif
        Reset = 1'b0;
    endtask

    task automatic test_sequence();
        logic [7:0] exp [0:8];
        exp = '{8'hBC, 8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};
        for (int i = 0; i < 9; i++) begin
            if (i == 0) send(1'b1, 8'hBC, 1'b1, 1'b0);
            else        send(1'b1, 8'h00, 1'b0, 1'b0);
            total++;
            if (bus.OutByte !== exp[i] || bus.OutValid !== 1'b1 || bus.OutControl !== (i == 0)) begin
                bad++;
                $display("FAIL seq_byte%0d got=%h/v%b/k%b exp=%h/v1/k%b", i, bus.OutByte,
                         bus.OutValid, bus.OutControl, exp[i], (i == 0));
            end
        end
    endtask

    task automatic test_skp();
        logic [7:0] inB [0:4];
        logic       inK [0:4];
        logic [7:0] exp [0:4];
        inB = '{8'hBC, 8'h00, 8'h1C, 8'h00, 8'h00};
        inK = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp = '{8'hBC, 8'hFF, 8'h1C, 8'h17, 8'hC0};
        for (int i = 0; i < 5; i++) begin
            send(1'b1, inB[i], inK[i], 1'b0);
            total++;
            if (bus.OutByte !== exp[i]) begin
                bad++;
                $display("FAIL skp_byte%0d got=%h exp=%h", i, bus.OutByte, exp[i]);
            end
        end
    endtask

    task automatic test_noscramble();
        send(1'b1, 8'hBC, 1'b1, 1'b0);
        send(1'b1, 8'h00, 1'b0, 1'b1);
        total++;
        if (bus.OutByte !== 8'h00) begin bad++; $display("FAIL nosc_bypass got=%h exp=00", bus.OutByte); end
`ifdef TX_DP_SCXOR_OUT_EN
        total++;
        if (bus.OutScXor !== 8'h00) begin bad++; $display("FAIL nosc_scxor got=%h exp=00", bus.OutScXor); end
`endif
        send(1'b1, 8'h00, 1'b0, 1'b0);
        total++;
        if (bus.OutByte !== 8'h17) begin bad++; $display("FAIL nosc_after got=%h exp=17", bus.OutByte); end
    endtask

    task automatic test_disable();
        bus.DisableScrambling = 1'b1;
        send(1'b1, 8'hBC, 1'b1, 1'b0);
        send(1'b1, 8'hA5, 1'b0, 1'b0);
        total++;
        if (bus.OutByte !== 8'hA5) begin bad++; $display("FAIL dis_a5 got=%h exp=a5", bus.OutByte); end
        send(1'b1, 8'h5A, 1'b0, 1'b0);
        total++;
        if (bus.OutByte !== 8'h5A) begin bad++; $display("FAIL dis_5a got=%h exp=5a", bus.OutByte); end
        bus.DisableScrambling = 1'b0;
        send(1'b1, 8'hBC, 1'b1, 1'b0);
        total++;
        if (bus.OutByte !== 8'hBC) begin bad++; $display("FAIL dis_com got=%h exp=bc", bus.OutByte); end
        send(1'b1, 8'h00, 1'b0, 1'b0);
        total++;
        if (bus.OutByte !== 8'hFF) begin bad++; $display("FAIL dis_reen got=%h exp=ff", bus.OutByte); end
    endtask

    task automatic test_gap();
        send(1'b1, 8'hBC, 1'b1, 1'b0);
        send(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
            total++;
            if (bus.OutValid !== 1'b0 || bus.OutByte !== 8'hFF || bus.OutControl !== 1'b0) begin
                bad++;
                $display("FAIL gap%0d got=v%b/%h/k%b exp=v0/ff/k0", i, bus.OutValid, bus.OutByte, bus.OutControl);
            end
        end
        send(1'b1, 8'h00, 1'b0, 1'b0);
        total++;
        if (bus.OutByte !== 8'h17 || bus.OutValid !== 1'b1) begin
            bad++; $display("FAIL gap_after got=%h/v%b exp=17/v1", bus.OutByte, bus.OutValid);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] exp [0:2];
        exp = '{8'hBC, 8'hFF, 8'h17};
        for (int i = 0; i < 3; i++) begin
            if (i == 0) send(1'b1, 8'hBC, 1'b1, 1'b0);
            else        send(1'b1, 8'h00, 1'b0, 1'b0);
            total++;
            if (bus.OutByte !== exp[i]) begin bad++; $display("FAIL rstmid_pre%0d got=%h exp=%h", i, bus.OutByte, exp[i]); end
`ifdef TX_DP_SCXOR_OUT_EN
            if (i > 0) begin
                total++;
                if (bus.OutScXor !== exp[i]) begin bad++; $display("FAIL rstmid_scxor%0d got=%h exp=%h", i, bus.OutScXor, exp[i]); end
            end
`endif
        end
        Reset = 1'b1;
        send(1'b1, 8'h00, 1'b0, 1'b0);
        Reset = 1'b0;
        total++;
        if (bus.OutValid !== 1'b0 || bus.OutByte !== 8'h00) begin
            bad++; $display("FAIL rstmid_rst got=v%b/%h exp=v0/00", bus.OutValid, bus.OutByte);
        end
`ifdef TX_DP_SCXOR_OUT_EN
        total++;
        if (bus.OutScXor !== 8'h00) begin bad++; $display("FAIL rstmid_rst_scxor got=%h exp=00", bus.OutScXor); end
`endif
        send(1'b1, 8'h00, 1'b0, 1'b0);
        total++;
        if (bus.OutByte !== 8'hFF) begin bad++; $display("FAIL rstmid_post got=%h exp=ff", bus.OutByte); end
`ifdef TX_DP_SCXOR_OUT_EN
        total++;
        if (bus.OutScXor !== 8'hFF) begin bad++; $display("FAIL rstmid_post_scxor got=%h exp=ff", bus.OutScXor); end
`endif
    endtask

    // Model: position into the keystream table, reset/COM to 0, SKP holds, every other byte consumes one
    task automatic test_random();
        logic [7:0] kSyms [0:7];
        int         keyPos;
        logic [7:0] eByte;
        logic [7:0] eXor;
        logic       eValid;
        logic       eCtl;
        logic       v, c, ns, rst;
        logic [7:0] b;
        kSyms  = '{8'hBC, 8'h1C, 8'hFC, 8'hF7, 8'h7C, 8'h3C, 8'hFE, 8'h5C};
        keyPos = 0;
        eByte  = 8'h00;
        eXor   = 8'h00;
        eValid = 1'b0;
        eCtl   = 1'b0;
        Reset  = 1'b1;
        send(1'b0, 8'h00, 1'b0, 1'b0);
        Reset  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 9) < 8);
            c   = ($urandom_range(0, 4) == 0);
            ns  = ($urandom_range(0, 9) == 0);
            b   = c ? kSyms[$urandom_range(0, 7)] : 8'($urandom);
            if (keyPos > 4000) begin c = 1'b1; b = 8'hBC; end
            if ($urandom_range(0, 49) == 0) bus.DisableScrambling = ~bus.DisableScrambling;
            if (rst) begin
                keyPos = 0; eValid = 1'b0; eByte = 8'h00; eCtl = 1'b0; eXor = 8'h00;
            end else if (v) begin
                eValid = 1'b1;
                eCtl   = c;
                if (c) begin
                    eByte = b;
                    eXor  = 8'h00;
                    if (b == 8'hBC) keyPos = 0;
                    else if (b != 8'h1C) keyPos++;
                end else begin
                    if (ns || bus.DisableScrambling) begin
                        eByte = b; eXor = 8'h00;
                    end else begin
                        eByte = b ^ keyStream[keyPos]; eXor = keyStream[keyPos];
                    end
                    keyPos++;
                end
            end else begin
                eValid = 1'b0;
            end
            Reset = rst;
            send(v, b, c, ns);
            Reset = 1'b0;
            total++;
            if (bus.OutValid !== eValid || bus.OutByte !== eByte || bus.OutControl !== eCtl) begin
                bad++;
                $display("FAIL rand%0d got=v%b/%h/k%b exp=v%b/%h/k%b", n, bus.OutValid, bus.OutByte,
                         bus.OutControl, eValid, eByte, eCtl);
            end
`ifdef TX_DP_SCXOR_OUT_EN
            total++;
            if (bus.OutScXor !== eXor) begin
                bad++; $display("FAIL rand_scxor%0d got=%h exp=%h", n, bus.OutScXor, eXor);
            end
`endif
        end
        bus.DisableScrambling = 1'b0;
    endtask

    initial begin
        bus.InValid           = 1'b0;
        bus.InByte            = 8'h00;
        bus.InControl         = 1'b0;
        bus.InNoScramble      = 1'b0;
        bus.DisableScrambling = 1'b0;
        build_keystream();
        test_reset();
        test_sequence();
        test_skp();
        test_noscramble();
        test_disable();
        test_gap();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
